// File: rtl/aes_stream_seq.sv
// aes_stream_seq: byte-serial sequencer between the UART command path and the
// masked AES core. Latches plaintext/key/trigger delay from UART writes, streams
// 16 plaintext/key byte pairs into the core on start, collects the 16 returned
// ciphertext bytes into one 128-bit word and emits a delayed scope trigger.
// Optional build macro: AES_SEQ_TIMEOUT_EN adds a WAIT-state watchdog that
// pulses timeout and abandons the run after TIMEOUT_CYC cycles without aes_done.
module aes_stream_seq #(
    parameter int BYTES       = 16,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         cfg_we,
    input  logic [7:0]   cfg_addr,
    input  logic [255:0] cfg_data,
    input  logic         start,
    output logic         busy,
    output logic [7:0]   pin,
    output logic [7:0]   kin,
    output logic         aes_start,
    input  logic         aes_done,
    input  logic [7:0]   cout,
    output logic [127:0] ctxt,
    output logic         ctxt_valid,
    output logic         trg,
    output logic         timeout
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_WAIT,
        S_CAPTURE,
        S_DONE
    } state_t;

    localparam logic [3:0] LAST_BYTE = 4'(BYTES - 1);

    state_t         r_state;
    state_t         w_next;
    logic [127:0]   r_ptxt;
    logic [127:0]   r_key;
    logic [7:0]     r_trg_delay;
    logic [127:0]   r_pt_sh;
    logic [127:0]   r_key_sh;
    logic [127:0]   r_ct_sh;
    logic [127:0]   r_ctxt;
    logic [3:0]     r_byte_cnt;
    logic [7:0]     r_trg_cnt;
    logic           w_last_byte;
    logic           w_aes_start;
    logic           w_wait_expire;

    assign w_last_byte = (r_byte_cnt == LAST_BYTE);
    assign w_aes_start = (r_state == S_LOAD) && (r_byte_cnt == 4'd0);

    // Configuration registers: writable in every state, unknown addresses ignored.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values;
    // this is also what makes a start coinciding with a ptxt write snapshot the old value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptxt      <= '0;
            r_key       <= '0;
            r_trg_delay <= '0;
        end else if (cfg_we) begin
            if (cfg_addr == 8'h01) begin
                r_ptxt <= cfg_data[127:0];
                r_key  <= cfg_data[255:128];
            end else if (cfg_addr == 8'h02) begin
                r_trg_delay <= cfg_data[7:0];
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // FSM next-state logic.
    // NOTE: w_next gets its default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (start) w_next = S_LOAD;
            S_LOAD:    if (w_last_byte) w_next = S_WAIT;
            S_WAIT: begin
                if (aes_done) begin
                    w_next = S_CAPTURE;
                end else if (w_wait_expire) begin
                    w_next = S_IDLE;
                end
            end
            S_CAPTURE: if (w_last_byte) w_next = S_DONE;
            S_DONE:    w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    // Byte counter, load/capture shift registers and the ciphertext output word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pt_sh    <= '0;
            r_key_sh   <= '0;
            r_ct_sh    <= '0;
            r_ctxt     <= '0;
            r_byte_cnt <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_pt_sh    <= r_ptxt;
                        r_key_sh   <= r_key;
                        r_byte_cnt <= 4'd0;
                    end
                end
                S_LOAD: begin
                    r_pt_sh    <= {r_pt_sh[119:0], 8'h00};
                    r_key_sh   <= {r_key_sh[119:0], 8'h00};
                    r_byte_cnt <= r_byte_cnt + 4'd1;
                end
                S_WAIT: begin
                    if (aes_done) begin
                        r_ct_sh    <= {r_ct_sh[119:0], cout};
                        r_byte_cnt <= 4'd1;
                    end
                end
                S_CAPTURE: begin
                    r_ct_sh    <= {r_ct_sh[119:0], cout};
                    r_byte_cnt <= r_byte_cnt + 4'd1;
                    // Final byte: publish the full word so it is stable throughout DONE.
                    if (w_last_byte) begin
                        r_ctxt <= {r_ct_sh[119:0], cout};
                    end
                end
                default: ;
            endcase
        end
    end

    // Trigger delay counter: reloaded on every aes_start, counts down to zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_trg_cnt <= '0;
        end else if (w_aes_start) begin
            r_trg_cnt <= r_trg_delay;
        end else if (r_trg_cnt != 8'd0) begin
            r_trg_cnt <= r_trg_cnt - 8'd1;
        end
    end

`ifdef AES_SEQ_TIMEOUT_EN
    localparam int WCW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    logic [WCW-1:0] r_wait_cnt;
    logic           r_timeout;

    // aes_done on the final counted cycle takes priority over expiry.
    assign w_wait_expire = (r_state == S_WAIT) && !aes_done &&
                           (r_wait_cnt == WCW'(TIMEOUT_CYC - 1));

    // Watchdog: counts WAIT cycles and registers a one-cycle timeout pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wait_cnt <= '0;
            r_timeout  <= 1'b0;
        end else begin
            r_timeout <= w_wait_expire;
            if (r_state == S_WAIT) begin
                r_wait_cnt <= r_wait_cnt + 1'b1;
            end else begin
                r_wait_cnt <= '0;
            end
        end
    end

    assign timeout = r_timeout;
`else
    assign w_wait_expire = 1'b0;
    assign timeout       = 1'b0;
`endif

    assign busy       = (r_state != S_IDLE);
    assign pin        = (r_state == S_LOAD) ? r_pt_sh[127:120]  : 8'h00;
    assign kin        = (r_state == S_LOAD) ? r_key_sh[127:120] : 8'h00;
    assign aes_start  = w_aes_start;
    assign ctxt       = r_ctxt;
    assign ctxt_valid = (r_state == S_DONE);
    assign trg        = (r_trg_cnt == 8'd1);

endmodule

// File: tb/tb_aes_stream_seq.sv
// Directed bench for aes_stream_seq (default build, watchdog disabled).
// A stub AES core returns known ciphertext bytes; expected values are constants.
module tb_aes_stream_seq;

    logic         clk;
    logic         rst_n;
    logic         cfg_we;
    logic [7:0]   cfg_addr;
    logic [255:0] cfg_data;
    logic         start;
    logic         busy;
    logic [7:0]   pin;
    logic [7:0]   kin;
    logic         aes_start;
    logic         aes_done;
    logic [7:0]   cout;
    logic [127:0] ctxt;
    logic         ctxt_valid;
    logic         trg;
    logic         timeout;

    int errors = 0;
    int checks = 0;

    localparam logic [127:0] KEY1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT1  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] KEY2 = 128'h0f0e0d0c0b0a09080706050403020100;
    localparam logic [127:0] PT2  = 128'hffeeddccbbaa99887766554433221100;
    localparam logic [127:0] CT2  = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;

    aes_stream_seq dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cfg_we     (cfg_we),
        .cfg_addr   (cfg_addr),
        .cfg_data   (cfg_data),
        .start      (start),
        .busy       (busy),
        .pin        (pin),
        .kin        (kin),
        .aes_start  (aes_start),
        .aes_done   (aes_done),
        .cout       (cout),
        .ctxt       (ctxt),
        .ctxt_valid (ctxt_valid),
        .trg        (trg),
        .timeout    (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_time_limit observed=running expected=finished");
        $fatal(1, "time limit");
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cfg_write(input logic [7:0] addr, input logic [255:0] data);
        cfg_we   = 1'b1;
        cfg_addr = addr;
        cfg_data = data;
        @(negedge clk);
        cfg_we   = 1'b0;
        cfg_addr = 8'h00;
        cfg_data = '0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Checks cycles T+1..T+16; trg expected on load index trg_at (-1: never).
    // With inject set, start and aes_done are pulsed mid-LOAD and must be ignored.
    task automatic check_load(input logic [127:0] pt, input logic [127:0] key,
                              input int trg_at, input bit inject);
        for (int k = 0; k < 16; k++) begin
            chk("load_pin", pin, pt[127-8*k -: 8]);
            chk("load_kin", kin, key[127-8*k -: 8]);
            chk("load_aes_start", aes_start, (k == 0));
            chk("load_busy", busy, 1'b1);
            chk("load_trg", trg, (k == trg_at));
            start    = inject && (k == 3);
            aes_done = inject && (k == 3);
            @(negedge clk);
        end
        start    = 1'b0;
        aes_done = 1'b0;
    endtask

    // Stub core: lat WAIT cycles, then aes_done with byte 0 and 15 more bytes.
    task automatic core_return(input logic [127:0] ct, input int lat, input logic [127:0] old_ctxt);
        for (int i = 0; i < lat; i++) begin
            chk("wait_pin", pin, 8'h00);
            chk("wait_kin", kin, 8'h00);
            chk("wait_busy", busy, 1'b1);
            chk("wait_trg", trg, 1'b0);
            @(negedge clk);
        end
        aes_done = 1'b1;
        cout     = ct[127:120];
        @(negedge clk);
        aes_done = 1'b0;
        for (int k = 1; k < 16; k++) begin
            cout = ct[127-8*k -: 8];
            chk("cap_ctxt_hold", ctxt, old_ctxt);
            chk("cap_valid", ctxt_valid, 1'b0);
            chk("cap_trg", trg, 1'b0);
            @(negedge clk);
        end
        cout = 8'h00;
        chk("done_valid", ctxt_valid, 1'b1);
        chk("done_ctxt", ctxt, ct);
        chk("done_busy", busy, 1'b1);
        @(negedge clk);
        chk("post_valid", ctxt_valid, 1'b0);
        chk("post_busy", busy, 1'b0);
        chk("post_ctxt", ctxt, ct);
    endtask

    initial begin
        rst_n    = 1'b0;
        cfg_we   = 1'b0;
        cfg_addr = 8'h00;
        cfg_data = '0;
        start    = 1'b0;
        aes_done = 1'b0;
        cout     = 8'h00;
        repeat (2) @(negedge clk);

        // Reset state
        chk("rst_busy", busy, 1'b0);
        chk("rst_aes_start", aes_start, 1'b0);
        chk("rst_trg", trg, 1'b0);
        chk("rst_valid", ctxt_valid, 1'b0);
        chk("rst_timeout", timeout, 1'b0);
        chk("rst_ctxt", ctxt, 128'h0);
        chk("rst_pin", pin, 8'h00);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_busy", busy, 1'b0);

        // aes_done in IDLE is ignored
        aes_done = 1'b1;
        cout     = 8'hAA;
        @(negedge clk);
        aes_done = 1'b0;
        cout     = 8'h00;
        @(negedge clk);
        chk("idle_done_ignored", busy, 1'b0);

        // Run 1: FIPS-197 vector, trg_delay 5, unknown address write ignored
        cfg_write(8'h01, {KEY1, PT1});
        cfg_write(8'h02, 256'd5);
        cfg_write(8'h03, {256{1'b1}});
        pulse_start();
        check_load(PT1, KEY1, 5, 1'b0);
        core_return(CT1, 4, 128'h0);
        chk("run1_timeout", timeout, 1'b0);

        // Run 2: trg_delay 0, ptxt write coincides with start, extra starts ignored
        cfg_write(8'h02, 256'd0);
        cfg_we   = 1'b1;
        cfg_addr = 8'h01;
        cfg_data = {KEY2, PT2};
        start    = 1'b1;
        @(negedge clk);
        cfg_we   = 1'b0;
        cfg_data = '0;
        start    = 1'b0;
        check_load(PT1, KEY1, -1, 1'b1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("wait_start_aes_start", aes_start, 1'b0);
        chk("wait_start_pin", pin, 8'h00);
        core_return(CT2, 2, CT1);

        // Run 3: new ptxt/key, trg_delay 1, reset during CAPTURE
        cfg_write(8'h02, 256'd1);
        pulse_start();
        check_load(PT2, KEY2, 1, 1'b0);
        @(negedge clk);
        aes_done = 1'b1;
        cout     = 8'h11;
        @(negedge clk);
        aes_done = 1'b0;
        for (int k = 1; k < 6; k++) begin
            cout = 8'h20 + 8'(k);
            @(negedge clk);
        end
        chk("cap_busy_pre_rst", busy, 1'b1);
        rst_n = 1'b0;
        cout  = 8'h00;
        #1;
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_pin", pin, 8'h00);
        chk("midrst_kin", kin, 8'h00);
        chk("midrst_trg", trg, 1'b0);
        chk("midrst_valid", ctxt_valid, 1'b0);
        chk("midrst_ctxt", ctxt, 128'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_busy", busy, 1'b0);
        chk("post_rst_valid", ctxt_valid, 1'b0);

        // Run 4: fresh run after reset (config cleared by reset, rewrite it)
        cfg_write(8'h01, {KEY1, PT1});
        cfg_write(8'h02, 256'd5);
        pulse_start();
        check_load(PT1, KEY1, 5, 1'b0);
        core_return(CT1, 3, 128'h0);
        chk("final_timeout", timeout, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
